// File: rtl/pe_row_qbuf_if.sv
// Row-level handshake bundle for pe_row_qbuf: left activation stream,
// right/below systolic pass-through, and the quantised result stream.
interface pe_row_qbuf_if #(
    parameter int NUM_PE    = 16,
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int FM_WIDTH  = 8
);
    localparam int IDX_W = $clog2(NUM_PE);

    logic                          in_vld_left;
    logic                          in_rdy_left;
    logic [ACT_WIDTH-1:0]          in_act_left;
    logic                          in_acc_reset_left;
    logic [WGT_WIDTH*NUM_PE-1:0]   in_wgt_above;

    logic [ACT_WIDTH-1:0]          out_act_right;
    logic                          out_vld_right;
    logic                          out_acc_reset_right;
    logic [WGT_WIDTH*NUM_PE-1:0]   out_wgt_below;

    logic                          out_vld;
    logic                          out_rdy;
    logic signed [FM_WIDTH-1:0]    out_fm;
    logic [IDX_W-1:0]              out_pe_idx;

    modport master (
        output in_vld_left, in_act_left, in_acc_reset_left, in_wgt_above,
        output out_rdy,
        input  in_rdy_left,
        input  out_act_right, out_vld_right, out_acc_reset_right,
        input  out_wgt_below,
        input  out_vld, out_fm, out_pe_idx
    );

    modport slave (
        input  in_vld_left, in_act_left, in_acc_reset_left, in_wgt_above,
        input  out_rdy,
        output in_rdy_left,
        output out_act_right, out_vld_right, out_acc_reset_right,
        output out_wgt_below,
        output out_vld, out_fm, out_pe_idx
    );
endinterface

// File: rtl/pe_row_qbuf.sv
// Systolic row of MAC PEs with per-PE result hold, shared two-stage
// requantiser and show-ahead output FIFO.
module pe_row_qbuf #(
    parameter int NUM_PE      = 16,
    parameter int ACT_WIDTH   = 8,
    parameter int WGT_WIDTH   = 8,
    parameter int PSUM_WIDTH  = ACT_WIDTH + WGT_WIDTH + 10,
    parameter int QNT_WIDTH   = 20,
    parameter int SHIFT_WIDTH = 5,
    parameter int FM_WIDTH    = 8,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [QNT_WIDTH-1:0]       quant_scale,
    input  logic [SHIFT_WIDTH-1:0]     quant_shift,
    input  logic signed [FM_WIDTH-1:0] quant_zero_point,
    pe_row_qbuf_if.slave               row
);
    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int PROD_W = ACT_WIDTH + WGT_WIDTH;
    localparam int QP_W   = PSUM_WIDTH + QNT_WIDTH;
    localparam int AW     = $clog2(OUT_DEPTH);
    localparam logic signed [QP_W+1:0] FM_MAX =
        {{(QP_W+3-FM_WIDTH){1'b0}}, {(FM_WIDTH-1){1'b1}}};
    localparam logic signed [QP_W+1:0] FM_MIN = ~FM_MAX;

    logic [NUM_PE-1:0][ACT_WIDTH-1:0]  act_q, act_in;
    logic [NUM_PE-1:0][WGT_WIDTH-1:0]  wgt_q, wgt_in;
    logic [NUM_PE-1:0][PSUM_WIDTH-1:0] acc_q, acc_nx, hold_q;
    logic [NUM_PE-1:0] vld_q, rst_q, vld_in, rst_in;
    logic [NUM_PE-1:0] used_q, hold_vld_q, drain_oh, cap;
    logic              adv, drain_any, drain, pipe_en;
    logic [IDX_W-1:0]  drain_idx;

    always_comb begin
        act_in = {act_q[NUM_PE-2:0], row.in_act_left};
        vld_in = {vld_q[NUM_PE-2:0], row.in_vld_left};
        rst_in = {rst_q[NUM_PE-2:0], row.in_acc_reset_left};
        wgt_in = row.in_wgt_above;
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
        logic signed [PROD_W-1:0] p;
        assign p = $signed(act_in[i]) * $signed(wgt_in[i]);
        assign acc_nx[i] = (rst_in[i] ? '0 : acc_q[i])
            + (vld_in[i] ? {{(PSUM_WIDTH-PROD_W){p[PROD_W-1]}}, p} : '0);
    end

    always_comb begin
        drain_idx = '0;
        drain_any = 1'b0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (hold_vld_q[i]) begin
                drain_idx = IDX_W'(i);
                drain_any = 1'b1;
            end
        end
    end

    // A reset arriving at a PE whose previous result is still held
    // must wait, unless that hold is being drained on the same edge.
    assign drain    = drain_any & pipe_en;
    assign drain_oh = drain ? ({{(NUM_PE-1){1'b0}}, 1'b1} << drain_idx) : '0;
    assign adv      = ~|(rst_in & hold_vld_q & ~drain_oh);
    assign cap      = {NUM_PE{adv}} & rst_in & used_q;
    assign row.in_rdy_left = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= '0;
            wgt_q      <= '0;
            vld_q      <= '0;
            rst_q      <= '0;
            acc_q      <= '0;
            used_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= '0;
        end else begin
            if (adv) begin
                act_q  <= act_in;
                wgt_q  <= wgt_in;
                vld_q  <= vld_in;
                rst_q  <= rst_in;
                acc_q  <= acc_nx;
                used_q <= vld_in | (used_q & ~rst_in);
            end
            hold_vld_q <= cap | (hold_vld_q & ~drain_oh);
            for (int i = 0; i < NUM_PE; i++) begin
                if (cap[i]) hold_q[i] <= acc_q[i];
            end
        end
    end

    assign row.out_act_right       = act_q[NUM_PE-1];
    assign row.out_vld_right       = vld_q[NUM_PE-1];
    assign row.out_acc_reset_right = rst_q[NUM_PE-1];
    assign row.out_wgt_below       = wgt_q;

    logic [PSUM_WIDTH-1:0]      psum_sel;
    logic signed [QP_W-1:0]     prod_nx, s1_prod;
    logic                       s1_vld, s2_vld;
    logic [IDX_W-1:0]           s1_idx, s2_idx;
    logic [SHIFT_WIDTH-1:0]     s1_shift;
    logic signed [FM_WIDTH-1:0] s1_zp, s2_fm, sat;
    logic signed [QP_W:0]       rbias, rnd, shd;
    logic signed [QP_W+1:0]     zsum;

    assign psum_sel = hold_q[drain_idx];
    assign prod_nx =
        $signed({{(QP_W-PSUM_WIDTH){psum_sel[PSUM_WIDTH-1]}}, psum_sel})
        * $signed({{(QP_W-QNT_WIDTH){1'b0}}, quant_scale});

    always_comb begin
        rbias = '0;
        if (s1_shift != '0) begin
            rbias = {{QP_W{1'b0}}, 1'b1} << (s1_shift - SHIFT_WIDTH'(1));
        end
        rnd  = {s1_prod[QP_W-1], s1_prod} + rbias;
        shd  = rnd >>> s1_shift;
        zsum = {shd[QP_W], shd}
             + {{(QP_W+2-FM_WIDTH){s1_zp[FM_WIDTH-1]}}, s1_zp};
        sat  = zsum[FM_WIDTH-1:0];
        if (zsum > FM_MAX) sat = FM_MAX[FM_WIDTH-1:0];
        if (zsum < FM_MIN) sat = FM_MIN[FM_WIDTH-1:0];
    end

    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, push, pop;
    logic [FM_WIDTH-1:0]  fm_mem  [OUT_DEPTH];
    logic [IDX_W-1:0]     idx_mem [OUT_DEPTH];

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = ~empty & row.out_rdy;
    assign pipe_en = ~(s2_vld & full & ~pop);
    assign push    = s2_vld & pipe_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_prod  <= '0;
            s1_idx   <= '0;
            s1_shift <= '0;
            s1_zp    <= '0;
            s2_vld   <= 1'b0;
            s2_fm    <= '0;
            s2_idx   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (pipe_en) begin
                s1_vld   <= drain_any;
                s1_prod  <= prod_nx;
                s1_idx   <= drain_idx;
                s1_shift <= quant_shift;
                s1_zp    <= quant_zero_point;
                s2_vld   <= s1_vld;
                s2_fm    <= sat;
                s2_idx   <= s1_idx;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fm_mem[wr_ptr[AW-1:0]]  <= s2_fm;
            idx_mem[wr_ptr[AW-1:0]] <= s2_idx;
        end
    end

    assign row.out_vld    = ~empty;
    assign row.out_fm     = empty ? '0 : fm_mem[rd_ptr[AW-1:0]];
    assign row.out_pe_idx = empty ? '0 : idx_mem[rd_ptr[AW-1:0]];
endmodule

// File: doc/pe_row_qbuf.md
PE_ROW_QBUF -- requirements
Module: PE_ROW_QBUF

Interface
REQ-001 SHALL have parameter NUM_PE, default 16, meaning number of PEs in the row (>=2).
REQ-002 SHALL have parameter ACT_WIDTH, default 8, meaning signed activation width.
REQ-003 SHALL have parameter WGT_WIDTH, default 8, meaning signed weight width.
REQ-004 SHALL have parameter PSUM_WIDTH, default ACT_WIDTH+WGT_WIDTH+10, meaning signed accumulator width.
REQ-005 SHALL have parameters QNT_WIDTH (20, unsigned scale width), SHIFT_WIDTH (5, shift width), FM_WIDTH (8, signed output width), OUT_DEPTH (4, output FIFO depth, power of 2, >=2).
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset; one clock, reset asynchronous active-low.
REQ-007 SHALL have ports: quant_scale in QNT_WIDTH; quant_shift in SHIFT_WIDTH; quant_zero_point in FM_WIDTH signed.
REQ-008 SHALL have ports: in_vld_left in 1; in_rdy_left out 1; in_act_left in ACT_WIDTH; in_acc_reset_left in 1; in_wgt_above in WGT_WIDTH*NUM_PE (PE i at slice i).
REQ-009 SHALL have ports: out_act_right out ACT_WIDTH; out_vld_right out 1; out_acc_reset_right out 1; out_wgt_below out WGT_WIDTH*NUM_PE.
REQ-010 SHALL have ports: out_vld out 1; out_rdy in 1; out_fm out FM_WIDTH; out_pe_idx out clog2(NUM_PE).

Function
REQ-011 SHALL advance the array (adv) in every cycle in_rdy_left=1; a beat with in_vld_left=0 enters as a bubble; nothing in the array changes when adv=0.
REQ-012 SHALL, on adv, register per PE i: act, vld, acc_reset, wgt; PE 0 inputs are the left ports, PE i>0 inputs are PE i-1 registers; wgt of PE i is in_wgt_above slice i.
REQ-013 SHALL, on adv, update acc[i] <= (rst_in[i] ? 0 : acc[i]) + (vld_in[i] ? act_in[i]*wgt_in[i] : 0), signed, wrap-around at PSUM_WIDTH.
REQ-014 SHALL keep per-PE used[i]: set on adv with vld_in[i]; cleared on adv with rst_in[i] unless vld_in[i].
REQ-015 SHALL, on adv with rst_in[i] and used[i], copy the pre-update acc[i] into hold[i] and set hold_vld[i]; with used[i]=0 no result is produced.
REQ-016 SHALL drain hold registers one per cycle, lowest pending index first, into quant stage S1 when S1 can accept; clears that hold_vld.
REQ-017 SHALL drive in_rdy_left=0 when any PE i has rst_in[i]=1, hold_vld[i]=1 and is not drained this cycle (collision stall); no result lost or overwritten.
REQ-018 SHALL compute S1: prod = psum * quant_scale (signed x unsigned, full width); S2: r = (prod + (shift>0 ? 2^(shift-1) : 0)) >>> shift, then + zero_point, saturated to [-2^(FM_WIDTH-1), 2^(FM_WIDTH-1)-1]; quant inputs sampled at S1.
REQ-019 SHALL carry the PE index with each result through S1, S2, FIFO to out_pe_idx.
REQ-020 SHALL write S2 into an OUT_DEPTH FIFO; S1/S2 stall while S2 valid and FIFO full with no pop; full FIFO with out_rdy=1 accepts write and read in the same cycle.
REQ-021 SHALL present FIFO head show-ahead: out_vld = not empty; pop when out_vld & out_rdy; out_fm/out_pe_idx stable while out_vld & ~out_rdy.
REQ-022 SHALL have minimum latency 3 cycles from capture edge to out_vld=1 (drain, S1, S2/FIFO write).
REQ-023 SHALL drive out_act_right, out_vld_right, out_acc_reset_right from PE NUM_PE-1 registers and out_wgt_below from all PE wgt registers.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously clear all act/wgt/vld/acc_reset/acc/used/hold_vld registers, S1/S2 valid, FIFO pointers; out_vld=0, out_fm=0, out_pe_idx=0, out_vld_right=0, out_acc_reset_right=0, out_act_right=0, out_wgt_below=0.
REQ-025 SHALL, mid-operation reset, discard all pending results; first output after release comes only from accumulations started after release.
REQ-026 SHALL drive in_rdy_left=1 in the first cycle after reset release.

Verification
REQ-027 NUM_PE=4, acts 1,2,3 w0=2, then reset pulse, scale=1 shift=0 zp=0 -> out_fm=12, out_pe_idx=0, out_vld 3 cycles after capture.
REQ-028 psum 5, scale 3, shift 2, zp 0 -> out_fm=4; psum -5 same settings -> out_fm=-4.
REQ-029 psum 100, scale 4, shift 0 -> 127; psum -200, scale 1 -> -128; psum 10, zp 120 -> 127.
REQ-030 out_rdy=0, back-to-back resets on 4 PEs -> FIFO fills, in_rdy_left drops on collision, after out_rdy=1 all results appear in PE index order, none lost.
REQ-031 Reset pulse with no prior valid beat -> no out_vld; rst_n asserted with 2 results pending -> out_vld=0 immediately and nothing emitted after release.
